// File: rtl/serial_sub.sv
`default_nettype none
// ==============================================================================
// serial_sub : bit-serial a - b - bi, LSB first, valid/ready result | rev 1.0
// ==============================================================================
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bi,
  output logic             busy,
  output logic [WIDTH:0]   out,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-2:0] diff_q, diff_d;
  logic [WIDTH:0]   out_q, out_d;
  logic             valid_q, valid_d;

  logic             bit_w;
  logic             br_next_w;
  logic             accept_w;
  logic [WIDTH-1:0] shift_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    br_d      = br_q;
    cnt_d     = cnt_q;
    diff_d    = diff_q;
    out_d     = out_q;
    valid_d   = valid_q;

    bit_w     = a_q[0] ^ b_q[0] ^ br_q;
    br_next_w = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    // Collected difference bits sit below the newest one; on the last edge this is the full result.
    shift_w   = {bit_w, diff_q};
    accept_w  = start & ((state_q == IDLE) | ((state_q == DONE) & valid_q & out_ready));

    case (state_q)
      RUN: begin
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        br_d   = br_next_w;
        diff_d = shift_w[WIDTH-1:1];
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          out_d   = {br_next_w, shift_w};
          valid_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (valid_q & out_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: ;
    endcase

    if (accept_w) begin
      a_d     = a;
      b_d     = b;
      br_d    = bi;
      cnt_d   = '0;
      state_d = RUN;
    end
  end

  assign busy      = (state_q != IDLE);
  assign out       = out_q;
  assign out_valid = valid_q;

endmodule
`default_nettype wire
